fft_mag_approx_fp: RTL and testbench

Computes an approximate FP32 spectral magnitude, |X| ≈ max + min·2^-BETA_SHIFT, from the per-bin absolute max/min pair produced by the max/min comparison stage that follows the FFT. It is a 3-stage pipeline with a valid flag. It flushes denormals, truncates toward zero, and saturates to +Inf. It also marks the last bin of each frame so the mel filterbank stage downstream can close its accumulation.

---
 rtl/fft_mag_approx_fp.sv | 137 +++++++++++++
 tb/tb_fft_mag_approx_fp.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fft_mag_approx_fp.sv
// rtl/fft_mag_approx_fp.sv - approximate FP32 magnitude max + min*2^-BETA_SHIFT, 3-stage pipeline with frame tagging
module fft_mag_approx_fp #(
    parameter int BETA_SHIFT = 2,
    parameter int FRAME_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] max_in,
    input  logic [31:0] min_in,
    output logic        valid_out,
    output logic [31:0] mag_out,
    output logic        last_out,
    output logic        ovf_sticky
);
    localparam logic [11:0] LAST_BIN = 12'(FRAME_LEN - 1);
    localparam logic [7:0]  BETA     = 8'(BETA_SHIFT);

    logic unused_sign;
    assign unused_sign = max_in[31] ^ min_in[31];

    logic [11:0] bin_cnt_q, bin_cnt_d;

    logic        s1_valid_q, s1_last_q, s1_nan_q, s1_inf_q;
    logic [30:0] s1_big_q, s1_small_q;
    logic        s1_nan_d, s1_inf_d;
    logic [30:0] s1_big_d, s1_small_d;

    logic        s2_valid_q, s2_last_q, s2_nan_q, s2_inf_q;
    logic [7:0]  s2_exp_q, s2_exp_d;
    logic [23:0] s2_mb_q, s2_ms_q, s2_mb_d, s2_ms_d;

    logic        valid_out_q, last_out_q, ovf_q;
    logic [31:0] mag_q, res_d;
    logic        sat_d;

    assign bin_cnt_d = (bin_cnt_q == LAST_BIN) ? 12'd0 : bin_cnt_q + 12'd1;

    // Stage 1: decode, scale the min operand, order the pair by magnitude.
    // Zero is carried as all-zero exponent/mantissa so it sorts below any normal.
    always_comb begin
        logic [30:0] a_val, b_val;
        logic        a_nan, b_nan, a_inf, b_inf;
        a_nan      = (&max_in[30:23]) && (|max_in[22:0]);
        b_nan      = (&min_in[30:23]) && (|min_in[22:0]);
        a_inf      = (&max_in[30:23]) && !(|max_in[22:0]);
        b_inf      = (&min_in[30:23]) && !(|min_in[22:0]);
        s1_nan_d   = a_nan || b_nan;
        s1_inf_d   = !s1_nan_d && (a_inf || b_inf);
        a_val      = (max_in[30:23] == 8'd0) ? 31'd0 : max_in[30:0];
        b_val      = (min_in[30:23] <= BETA) ? 31'd0
                                             : {min_in[30:23] - BETA, min_in[22:0]};
        s1_big_d   = a_val;
        s1_small_d = b_val;
        if (b_val > a_val) begin
            s1_big_d   = b_val;
            s1_small_d = a_val;
        end
    end

    // Stage 2: align the smaller mantissa to the larger exponent (truncating).
    always_comb begin
        logic [7:0]  d;
        logic [23:0] ms_full;
        d        = s1_big_q[30:23] - s1_small_q[30:23];
        s2_exp_d = s1_big_q[30:23];
        s2_mb_d  = (s1_big_q[30:23] == 8'd0) ? 24'd0 : {1'b1, s1_big_q[22:0]};
        ms_full  = (s1_small_q[30:23] == 8'd0) ? 24'd0 : {1'b1, s1_small_q[22:0]};
        s2_ms_d  = (d >= 8'd24) ? 24'd0 : (ms_full >> d);
    end

    // Stage 3: add, renormalize on carry, saturate or substitute specials.
    always_comb begin
        logic [24:0] sum;
        logic [8:0]  e9;
        logic [22:0] man;
        sum = {1'b0, s2_mb_q} + {1'b0, s2_ms_q};
        if (sum[24]) begin
            e9  = {1'b0, s2_exp_q} + 9'd1;
            man = sum[23:1];
        end else begin
            e9  = {1'b0, s2_exp_q};
            man = sum[22:0];
        end
        sat_d = !s2_nan_q && !s2_inf_q && (e9 >= 9'd255);
        if (s2_nan_q)                  res_d = 32'h7FC0_0000;
        else if (s2_inf_q || sat_d)    res_d = 32'h7F80_0000;
        else                           res_d = {1'b0, e9[7:0], man};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt_q   <= 12'd0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_big_q    <= 31'd0;
            s1_small_q  <= 31'd0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_exp_q    <= 8'd0;
            s2_mb_q     <= 24'd0;
            s2_ms_q     <= 24'd0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            mag_q       <= 32'd0;
            ovf_q       <= 1'b0;
        end else begin
            if (valid_in) bin_cnt_q <= bin_cnt_d;
            s1_valid_q  <= valid_in;
            s1_last_q   <= valid_in && (bin_cnt_q == LAST_BIN);
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s1_big_q    <= s1_big_d;
            s1_small_q  <= s1_small_d;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_nan_q    <= s1_nan_q;
            s2_inf_q    <= s1_inf_q;
            s2_exp_q    <= s2_exp_d;
            s2_mb_q     <= s2_mb_d;
            s2_ms_q     <= s2_ms_d;
            valid_out_q <= s2_valid_q;
            last_out_q  <= s2_valid_q && s2_last_q;
            if (s2_valid_q) mag_q <= res_d;
            if (s2_valid_q && sat_d) ovf_q <= 1'b1;
        end
    end

    assign valid_out  = valid_out_q;
    assign mag_out    = mag_q;
    assign last_out   = last_out_q;
    assign ovf_sticky = ovf_q;
endmodule

// File: tb/tb_fft_mag_approx_fp.sv
// tb/tb_fft_mag_approx_fp.sv - directed self-checking bench for fft_mag_approx_fp
module tb_fft_mag_approx_fp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] max_in = 32'd0;
    logic [31:0] min_in = 32'd0;
    logic        valid_out, last_out, ovf_sticky;
    logic [31:0] mag_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] sched, obs_v, obs_l;

    fft_mag_approx_fp #(.BETA_SHIFT(2), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .max_in(max_in), .min_in(min_in),
        .valid_out(valid_out), .mag_out(mag_out),
        .last_out(last_out), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_one(input logic [31:0] mx, input logic [31:0] mn,
                            input logic [31:0] expv, input string tag);
        @(posedge clk); #1;
        valid_in = 1'b1; max_in = mx; min_in = mn;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_early"}, 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_mag"}, mag_out, expv);
    endtask

    task automatic run_sched(input int ncyc);
        obs_v = '0;
        obs_l = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            obs_v[c] = valid_out;
            obs_l[c] = last_out;
            valid_in = sched[c];
            max_in = 32'h3F80_0000;
            min_in = 32'h3F80_0000;
        end
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        n_bad++;
        $error("FAIL timeout: stimulus did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_mag", mag_out, 32'h0000_0000);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        rst_n = 1'b1;

        send_one(32'h3F80_0000, 32'h3F80_0000, 32'h3FA0_0000, "basic");
        chk("basic_last", 32'(last_out), 32'd0);
        send_one(32'h4040_0000, 32'h4080_0000, 32'h4080_0000, "swap");
        send_one(32'h3FC0_0000, 32'h4000_0000, 32'h4000_0000, "carry");
        send_one(32'h3F80_0000, 32'h3480_0000, 32'h3F80_0000, "d24");
        send_one(32'h3F80_0000, 32'h0000_0001, 32'h3F80_0000, "denorm");
        send_one(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "zeros");
        send_one(32'hFF80_0000, 32'h3F80_0000, 32'h7F80_0000, "inf");
        chk("inf_ovf", 32'(ovf_sticky), 32'd0);
        send_one(32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, "nan");
        chk("nan_ovf", 32'(ovf_sticky), 32'd0);
        send_one(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, "sat");
        chk("sat_ovf", 32'(ovf_sticky), 32'd1);
        @(posedge clk); #1;
        chk("hold_valid", 32'(valid_out), 32'd0);
        chk("hold_mag", mag_out, 32'h7F80_0000);
        chk("hold_last", 32'(last_out), 32'd0);
        send_one(32'hBF80_0000, 32'hBF80_0000, 32'h3FA0_0000, "signs");
        chk("ovf_held", 32'(ovf_sticky), 32'd1);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sched = 20'h00FE7;
        run_sched(20);
        chk("frame_valid_pattern", 32'(obs_v), 32'h0000_7F38);
        chk("frame_last_pattern", 32'(obs_l), 32'h0000_1100);
        chk("frame_mag", mag_out, 32'h3FA0_0000);

        sched = 20'h00007;
        run_sched(4);
        chk("pre_rst_valid", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_mag", mag_out, 32'h0000_0000);
        chk("mid_rst_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sched = 20'h0000F;
        run_sched(12);
        chk("post_rst_valid_pattern", 32'(obs_v), 32'h0000_0078);
        chk("post_rst_last_pattern", 32'(obs_l), 32'h0000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
